// File: rtl/multi_adder_with_flow_control.sv
// N-channel flow-controlled adder: each valid/ready input stream is buffered in its own FIFO,
// and one registered sum is emitted per complete set of operands.
module multi_adder_with_flow_control #(
   parameter int unsigned width    = 4,
   parameter int unsigned n_inputs = 3,
   parameter int unsigned depth    = 2
) (
   input  logic                                clk,
   input  logic                                rst,
   input  logic [n_inputs-1:0]                 in_vld,
   output logic [n_inputs-1:0]                 in_rdy,
   input  logic [n_inputs*width-1:0]           in_data,
   output logic                                sum_vld,
   input  logic                                sum_rdy,
   output logic [width+$clog2(n_inputs)-1:0]   sum_data
);

   localparam int unsigned SW = width + $clog2(n_inputs);
   localparam int unsigned PW = (depth > 1) ? $clog2(depth) : 1;
   localparam int unsigned CW = $clog2(depth + 1);

   logic [n_inputs-1:0] full;
   logic [n_inputs-1:0] empty;
   logic [width-1:0]    head [n_inputs];
   logic                fire;

   logic [SW-1:0]       sum_q, sum_d;
   logic                vld_q, vld_d;
   logic [SW-1:0]       sum_c;

   // Ready depends only on FIFO occupancy and reset, never on in_vld or sum_rdy.
   assign in_rdy = ~full & {n_inputs{~rst}};
   assign fire   = (&(~empty)) & (~vld_q | sum_rdy);

   for (genvar g = 0; g < n_inputs; g++) begin : g_fifo
      logic [width-1:0] mem_q [depth];
      logic [PW-1:0]    wr_q, wr_d;
      logic [PW-1:0]    rd_q, rd_d;
      logic [CW-1:0]    cnt_q, cnt_d;
      logic             push;

      assign push     = in_vld[g] & in_rdy[g];
      assign full[g]  = (cnt_q == CW'(depth));
      assign empty[g] = (cnt_q == '0);
      assign head[g]  = mem_q[rd_q];

      // Pointers wrap explicitly so non-power-of-2 depths work.
      always_comb begin
         wr_d  = wr_q;
         rd_d  = rd_q;
         cnt_d = cnt_q;
         if (push) begin
            wr_d = (wr_q == PW'(depth - 1)) ? '0 : wr_q + PW'(1);
         end
         if (fire) begin
            rd_d = (rd_q == PW'(depth - 1)) ? '0 : rd_q + PW'(1);
         end
         if (push && !fire) begin
            cnt_d = cnt_q + CW'(1);
         end else if (fire && !push) begin
            cnt_d = cnt_q - CW'(1);
         end
      end

      always_ff @(posedge clk) begin
         if (rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
         end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
         end
      end

      always_ff @(posedge clk) begin
         if (push) begin
            mem_q[wr_q] <= in_data[g*width +: width];
         end
      end
   end

   always_comb begin
      sum_c = '0;
      for (int unsigned i = 0; i < n_inputs; i++) begin
         sum_c = sum_c + SW'(head[i]);
      end
   end

   always_comb begin
      sum_d = sum_q;
      vld_d = vld_q;
      if (fire) begin
         sum_d = sum_c;
         vld_d = 1'b1;
      end else if (vld_q && sum_rdy) begin
         vld_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sum_q <= '0;
         vld_q <= 1'b0;
      end else begin
         sum_q <= sum_d;
         vld_q <= vld_d;
      end
   end

   assign sum_vld  = vld_q;
   assign sum_data = sum_q;

endmodule

// File: tb/tb_multi_adder_with_flow_control.sv
// Directed and random bench for multi_adder_with_flow_control; expected sums come from
// per-channel queues of accepted operands, consumed on every output handshake.
module tb_multi_adder_with_flow_control;
   localparam int W  = 4;
   localparam int N  = 3;
   localparam int D  = 2;
   localparam int SW = 6;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic [N-1:0]    in_vld = '0;
   logic [N-1:0]    in_rdy;
   logic [N*W-1:0]  in_data = '0;
   logic            sum_vld;
   logic            sum_rdy = 1'b0;
   logic [SW-1:0]   sum_data;

   int errors = 0;
   int checks = 0;
   int nsum   = 0;
   int acc_cnt [N];
   logic [W-1:0] mq [N][$];

   logic [N-1:0]  obs_rdy;
   logic          obs_vld;
   logic [SW-1:0] obs_data;
   logic          hold_pend = 1'b0;
   logic [SW-1:0] hold_data = '0;

   always #5 clk = ~clk;

   multi_adder_with_flow_control #(
      .width(W),
      .n_inputs(N),
      .depth(D)
   ) dut (
      .clk(clk),
      .rst(rst),
      .in_vld(in_vld),
      .in_rdy(in_rdy),
      .in_data(in_data),
      .sum_vld(sum_vld),
      .sum_rdy(sum_rdy),
      .sum_data(sum_data)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One clock cycle: drive at negedge, sample #1 later, update the model at the posedge.
   task automatic cycle(input logic r_st, input logic [N-1:0] v, input logic [N*W-1:0] d,
                        input logic r);
      logic [N-1:0] acc;
      logic [N-1:0] have;
      int           e;
      rst = r_st; in_vld = v; in_data = d; sum_rdy = r;
      #1;
      obs_rdy = in_rdy; obs_vld = sum_vld; obs_data = sum_data;
      if (hold_pend) begin
         check("hold_vld", 32'(sum_vld), 32'(1));
         check("hold_data", 32'(sum_data), 32'(hold_data));
      end
      if (sum_vld === 1'b1 && sum_rdy) begin
         for (int i = 0; i < N; i++) have[i] = (mq[i].size() != 0);
         check("sum_has_operands", 32'(have), 32'(3'b111));
         if (have == 3'b111) begin
            e = 0;
            for (int i = 0; i < N; i++) e += int'(mq[i].pop_front());
            check("sum", 32'(sum_data), e);
         end
         nsum++;
      end
      acc = v & in_rdy;
      for (int i = 0; i < N; i++) begin
         if (acc[i] === 1'b1) begin
            mq[i].push_back(d[i*W +: W]);
            acc_cnt[i]++;
         end
      end
      hold_pend = (sum_vld === 1'b1) && !r && !r_st;
      hold_data = sum_data;
      @(posedge clk);
      if (r_st) for (int i = 0; i < N; i++) mq[i].delete();
      @(negedge clk);
   endtask

   task automatic drain(input int n);
      for (int c = 0; c < n; c++) cycle(1'b0, '0, '0, 1'b1);
      for (int i = 0; i < N; i++) check("queue_empty", 32'(mq[i].size()), 32'(0));
      check("drain_vld", 32'(obs_vld), 32'(0));
   endtask

   task automatic clr_acc();
      for (int i = 0; i < N; i++) acc_cnt[i] = 0;
   endtask

   initial begin
      int n0;
      logic [N-1:0] v;
      logic [SW-1:0] first_data;
      logic seen;
      clr_acc();
      @(negedge clk);

      // 1: reset behaviour
      for (int c = 0; c < 3; c++) begin
         cycle(1'b1, '0, '0, 1'b0);
         check("rst_rdy", 32'(obs_rdy), 32'(0));
         if (c > 0) check("rst_vld", 32'(obs_vld), 32'(0));
      end
      cycle(1'b0, '0, '0, 1'b0);
      check("post_rst_rdy", 32'(obs_rdy), 32'(3'b111));
      check("post_rst_vld", 32'(obs_vld), 32'(0));
      check("post_rst_data", 32'(obs_data), 32'(0));

      // 2: streaming F+F+F at full throughput
      for (int c = 0; c < 6; c++) begin
         cycle(1'b0, 3'b111, 12'hFFF, 1'b1);
         check("t2_rdy", 32'(obs_rdy), 32'(3'b111));
         check("t2_vld", 32'(obs_vld), 32'(c >= 2));
         if (c >= 2) check("t2_data", 32'(obs_data), 32'(6'h2D));
      end
      drain(3);

      // 3: one channel idle, then supplies the missing operands
      clr_acc();
      for (int c = 0; c < 4; c++) cycle(1'b0, 3'b011, 12'h021, 1'b1);
      check("t3_acc0", 32'(acc_cnt[0]), 32'(2));
      check("t3_acc1", 32'(acc_cnt[1]), 32'(2));
      check("t3_rdy", 32'(obs_rdy[1:0]), 32'(0));
      check("t3_vld", 32'(obs_vld), 32'(0));
      n0 = nsum;
      for (int c = 0; c < 2; c++) cycle(1'b0, 3'b100, 12'h300, 1'b1);
      drain(4);
      check("t3_acc2", 32'(acc_cnt[2]), 32'(2));
      check("t3_nsum", 32'(nsum - n0), 32'(2));

      // 4: output stalled, storage limit, then ordered drain
      clr_acc();
      seen = 1'b0;
      first_data = '0;
      for (int c = 0; c < 6; c++) begin
         cycle(1'b0, 3'b111, 12'($urandom), 1'b0);
         if (obs_vld === 1'b1) begin
            if (!seen) first_data = obs_data;
            else check("t4_stable", 32'(obs_data), 32'(first_data));
            seen = 1'b1;
         end
      end
      for (int i = 0; i < N; i++) check("t4_acc", 32'(acc_cnt[i]), 32'(3));
      check("t4_rdy", 32'(obs_rdy), 32'(0));
      check("t4_vld", 32'(obs_vld), 32'(1));
      n0 = nsum;
      drain(4);
      check("t4_nsum", 32'(nsum - n0), 32'(3));

      // 5: reset with full FIFOs and a pending sum
      for (int c = 0; c < 5; c++) cycle(1'b0, 3'b111, 12'($urandom), 1'b0);
      cycle(1'b1, '0, '0, 1'b0);
      check("t5_rst_rdy", 32'(obs_rdy), 32'(0));
      n0 = nsum;
      for (int c = 0; c < 4; c++) begin
         cycle(1'b0, '0, '0, 1'b1);
         check("t5_vld", 32'(obs_vld), 32'(0));
         check("t5_rdy", 32'(obs_rdy), 32'(3'b111));
      end
      check("t5_nsum", 32'(nsum - n0), 32'(0));

      // 6: random valid/ready, 100 items per channel
      clr_acc();
      n0 = nsum;
      for (int c = 0; c < 3000 && (nsum - n0) < 100; c++) begin
         for (int i = 0; i < N; i++) v[i] = (acc_cnt[i] < 100) && ($urandom_range(3) != 0);
         cycle(1'b0, v, 12'($urandom), $urandom_range(3) != 0);
      end
      check("t6_nsum", 32'(nsum - n0), 32'(100));
      for (int i = 0; i < N; i++) check("t6_acc", 32'(acc_cnt[i]), 32'(100));
      for (int i = 0; i < N; i++) check("t6_queue_empty", 32'(mq[i].size()), 32'(0));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
